// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with wrap or saturate at the range ends.
// Provides a combinational terminal-count flag, a one-cycle end-event pulse and a sticky overflow flag.
module updown_mod_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam bit               SAT   = (SATURATE != 0);

    logic [WIDTH-1:0] cnt_nxt;
    logic             wrap_nxt;
    logic             ovf_nxt;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (cnt == MAX_V);
    assign at_zero = (cnt == '0);

    // The next enabled step leaves the legal range in the current direction.
    assign tc = en & ~clr & ~load & ((up_dn & at_max) | (~up_dn & at_zero));

    // Next-state logic; priority is clr > load > en > hold.
    always_comb begin
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        ovf_nxt  = ovf;
        if (clr) begin
            cnt_nxt = RST_V;
            ovf_nxt = 1'b0;
        end else if (load) begin
            cnt_nxt = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            if (up_dn) begin
                if (at_max) begin
                    wrap_nxt = 1'b1;
                    ovf_nxt  = 1'b1;
                    cnt_nxt  = SAT ? MAX_V : '0;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end else begin
                if (at_zero) begin
                    wrap_nxt = 1'b1;
                    ovf_nxt  = 1'b1;
                    cnt_nxt  = SAT ? '0 : MAX_V;
                end else begin
                    cnt_nxt = cnt - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= RST_V;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            wrap <= wrap_nxt;
            ovf  <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter: four parameter variants share one stimulus stream
// and are compared against an arithmetic reference model.
module tb_updown_mod_counter;

    localparam int N = 4;
    // Variants: 0 wrap mod 10, 1 saturate 0..9, 2 defaults (mod 16), 3 wrap mod 10 with RST_VAL=3
    localparam int MAXV [N] = '{9, 9, 15, 9};
    localparam int SATV [N] = '{0, 1, 0, 0};
    localparam int RSTV [N] = '{0, 0, 0, 3};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] cnt  [N];
    logic       tc   [N];
    logic       wrap [N];
    logic       ovf  [N];

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .RST_VAL(0)) u_wrap9 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .cnt(cnt[0]), .tc(tc[0]), .wrap(wrap[0]), .ovf(ovf[0]));

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .RST_VAL(0)) u_sat9 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .cnt(cnt[1]), .tc(tc[1]), .wrap(wrap[1]), .ovf(ovf[1]));

    updown_mod_counter #(.WIDTH(4)) u_def (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .cnt(cnt[2]), .tc(tc[2]), .wrap(wrap[2]), .ovf(ovf[2]));

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .RST_VAL(3)) u_rst3 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .cnt(cnt[3]), .tc(tc[3]), .wrap(wrap[3]), .ovf(ovf[3]));

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   tc;
        logic [N-1:0]   wrap;
        logic [N-1:0]   ovf;
        logic [4*N-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   mc [N];
    int   mo [N];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Apply one edge of stimulus and push the model's expected response.
    task automatic step(input logic c, input logic l, input logic e, input logic u, input int lv);
        exp_t x;
        @(posedge clk);
        #2;
        clr = c; load = l; en = e; up_dn = u; load_val = 4'(lv);
        for (int i = 0; i < N; i++) begin
            int mx;
            int n;
            mx = MAXV[i];
            x.tc[i]   = e && !c && !l && ((u && mc[i] == mx) || (!u && mc[i] == 0));
            x.wrap[i] = 1'b0;
            if (c) begin
                mc[i] = RSTV[i];
                mo[i] = 0;
            end else if (l) begin
                mc[i] = (lv > mx) ? mx : lv;
            end else if (e) begin
                n = u ? mc[i] + 1 : mc[i] - 1;
                if (n > mx || n < 0) begin
                    x.wrap[i] = 1'b1;
                    mo[i] = 1;
                    if (SATV[i] != 0) n = (n < 0) ? 0 : mx;
                end
                mc[i] = (n + mx + 1) % (mx + 1);
            end
            x.cnt[i*4 +: 4] = 4'(mc[i]);
            x.ovf[i] = (mo[i] != 0);
        end
        q.push_back(x);
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_cnt[%0d]", tag, i), int'(cnt[i]), RSTV[i]);
            check($sformatf("%s_wrap[%0d]", tag, i), int'(wrap[i]), 0);
            check($sformatf("%s_ovf[%0d]", tag, i), int'(ovf[i]), 0);
        end
    endtask

    // Pull reset between edges, hold it with junk on the controls, then release between edges.
    task automatic async_reset(input int hold_edges);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_immediate");
        clr = 1'bx; load = 1'bx; en = 1'bx; up_dn = 1'bx; load_val = 4'bxxxx;
        repeat (hold_edges) @(posedge clk);
        #1;
        check_reset_state("rst_hold");
        clr = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b0; load_val = 4'd0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            mc[i] = RSTV[i];
            mo[i] = 0;
        end
    endtask

    // Monitor: tc is sampled mid-cycle, registered outputs just after the consuming edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                for (int i = 0; i < N; i++)
                    check($sformatf("tc[%0d]", i), int'(tc[i]), int'(e.tc[i]));
                @(posedge clk);
                #1;
                for (int i = 0; i < N; i++) begin
                    check($sformatf("cnt[%0d]", i), int'(cnt[i]), int'(e.cnt[i*4 +: 4]));
                    check($sformatf("wrap[%0d]", i), int'(wrap[i]), int'(e.wrap[i]));
                    check($sformatf("ovf[%0d]", i), int'(ovf[i]), int'(e.ovf[i]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_state("por");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            mc[i] = RSTV[i];
            mo[i] = 0;
        end

        // Count to 5, reset mid-count, then resume.
        repeat (5) step(0, 0, 1, 1, 0);
        async_reset(2);
        repeat (3) step(0, 0, 1, 1, 0);

        // Up through the wrap point from 0.
        step(1, 0, 0, 0, 0);
        repeat (11) step(0, 0, 1, 1, 0);

        // Down wrap from 1.
        step(0, 1, 0, 0, 1);
        repeat (3) step(0, 0, 1, 0, 0);

        // Saturate scenario: up from 7 for 5 edges, then down 3.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 7);
        repeat (5) step(0, 0, 1, 1, 0);
        repeat (3) step(0, 0, 1, 0, 0);

        // Load clamp and control priority.
        step(0, 1, 0, 0, 12);
        step(1, 1, 1, 1, 5);
        step(0, 1, 1, 1, 3);

        // Hold at 4, then full default-width cycle from 0.
        step(0, 1, 0, 0, 4);
        repeat (10) step(0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0);
        repeat (16) step(0, 0, 1, 1, 0);

        // Randomised traffic with an occasional mid-run reset.
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 99));
            if (k == 200) async_reset(1);
            step(r < 4, (r >= 4 && r < 14), ($urandom_range(0, 9) < 8),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        end

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        #3;
        check("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
